// File: rtl/stopwatch_display.sv
// mm:ss.cc BCD stopwatch driving six active-low seven-segment displays (HEX5..HEX0).
// Define STOPWATCH_LAP_HOLD_EN to add the lap input that freezes the display while counting continues.
module stopwatch_display #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       run,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       running,
  output logic       wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  // Digit order {m1, m0, s1, s0, cs1, cs0}
  localparam logic [5:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0][3:0] digits_q, digits_d;
  logic [5:0][3:0] shown;
  logic [5:0][6:0] hex_q;
  logic [5:0]      carry;
  logic            tick, wrap_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    tick     = (state_q == RUNNING) && (presc_q == PRESC_LAST);
    wrap_d   = tick && (digits_q == DIGIT_MAX);

    // A digit advances only when every lower digit is at its maximum.
    carry[0] = tick;
    for (int i = 1; i < 6; i++) begin
      carry[i] = carry[i-1] && (digits_q[i-1] == DIGIT_MAX[i-1]);
    end
    for (int i = 0; i < 6; i++) begin
      if (carry[i]) begin
        digits_d[i] = (digits_q[i] == DIGIT_MAX[i]) ? 4'd0 : digits_q[i] + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (run) state_d = RUNNING;
      end
      RUNNING: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (!run) state_d = PAUSED;
      end
      PAUSED: begin
        if (run) begin
          state_d = RUNNING;
        end else if (clear) begin
          state_d  = IDLE;
          presc_d  = '0;
          digits_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic            hold_q, hold_d;
  logic [5:0][3:0] lap_q, lap_d;

  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if ((state_q == RUNNING) && lap) begin
      hold_d = !hold_q;
      if (!hold_q) lap_d = digits_q;
    end else if (state_d == IDLE) begin
      hold_d = 1'b0;
    end
    // Display follows the post-edge hold decision so capture and release take effect immediately.
    shown = hold_d ? lap_d : digits_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
      lap_q  <= '0;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
    end
  end
`else
  always_comb shown = digits_q;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      digits_q <= '0;
      wrap     <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= 7'b1000000;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      wrap     <= wrap_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= seg7(shown[i]);
    end
  end

  assign running = (state_q == RUNNING);
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: reference model keeps time as an integer count of hundredths.
// Build with STOPWATCH_LAP_HOLD_EN defined to exercise the lap-hold display.
module tb_stopwatch_display;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MAX_T   = 360000;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap = 1'b0;
`endif
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       running, wrap;
  logic [6:0] hex_obs [6];

  int checks = 0;
  int errors = 0;

  int m_state, m_phase, m_time, m_shown, m_hold, m_hold_t;
  bit m_wrap;

  stopwatch_display #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .run     (run),
    .clear   (clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap     (lap),
`endif
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX2    (hex2),
    .HEX3    (hex3),
    .HEX4    (hex4),
    .HEX5    (hex5),
    .running (running),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  always_comb begin
    hex_obs[0] = hex0;
    hex_obs[1] = hex1;
    hex_obs[2] = hex2;
    hex_obs[3] = hex3;
    hex_obs[4] = hex4;
    hex_obs[5] = hex5;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected pattern of display idx for a time given in hundredths.
  function automatic logic [6:0] exp_hex(input int t, input int idx);
    int cs, s, m, d;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = t / 6000;
    case (idx)
      0: d = cs % 10;
      1: d = cs / 10;
      2: d = s % 10;
      3: d = s / 10;
      4: d = m % 10;
      default: d = m / 10;
    endcase
    return seg_of(d);
  endfunction

  function automatic void update_model();
    bit tick;
    int nt, nh, nht;
    if (!reset_n) begin
      m_state = S_IDLE; m_phase = 0; m_time = 0; m_shown = 0;
      m_wrap = 1'b0; m_hold = 0; m_hold_t = 0;
      return;
    end
    tick   = (m_state == S_RUN) && (m_phase == DIV - 1);
    m_wrap = tick && (m_time == MAX_T - 1);
    nt     = tick ? (m_time + 1) % MAX_T : m_time;
    nh     = m_hold;
    nht    = m_hold_t;
`ifdef STOPWATCH_LAP_HOLD_EN
    if (m_state == S_RUN && lap) begin
      if (m_hold != 0) nh = 0;
      else begin nh = 1; nht = m_time; end
    end
`endif
    if (m_state == S_RUN) m_phase = tick ? 0 : m_phase + 1;
    case (m_state)
      S_IDLE:  if (run) m_state = S_RUN;
      S_RUN:   if (!run) m_state = S_PAUSE;
      default: begin
        if (run) m_state = S_RUN;
        else if (clear) begin
          m_state = S_IDLE; m_phase = 0; nt = 0; nh = 0;
        end
      end
    endcase
    m_shown  = (nh != 0) ? nht : m_time;
    m_time   = nt;
    m_hold   = nh;
    m_hold_t = nht;
  endfunction

  task automatic cycle();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    lap = 1'b0;
`endif
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  // Leaves the DUT paused with the given time loaded into its digit registers.
  task automatic preload(input bit full);
    run = 1'b1; cycle();
    run = 1'b0; cycle();
    if (full) force dut.digits_q = 24'h595999;
    else      force dut.digits_q = 24'h000999;
    m_time = full ? 359999 : 999;
    cycle();
    release dut.digits_q;
  endtask

  task automatic test_reset();
    do_reset();
    for (int h = 0; h < 6; h++) begin
      checks++;
      if (hex_obs[h] !== 7'b1000000) begin
        errors++; $display("FAIL reset_hex%0d: got %b want 1000000", h, hex_obs[h]);
      end
    end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
  endtask

  task automatic test_basic_count();
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      cycle();
      checks++;
      if (running !== 1'(m_state == S_RUN)) begin
        errors++; $display("FAIL basic_running cyc %0d: got %b want %b", c, running, m_state == S_RUN);
      end
      checks++;
      if (hex0 !== exp_hex(m_shown, 0)) begin
        errors++; $display("FAIL basic_hex0 cyc %0d: got %b want %b", c, hex0, exp_hex(m_shown, 0));
      end
      if (c == 1) begin
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL basic_run_latency: got %b want 1", running); end
      end
    end
    checks++;
    if (hex0 !== 7'b0100100) begin errors++; $display("FAIL basic_final_hex0: got %b want 0100100", hex0); end
    for (int h = 1; h < 6; h++) begin
      checks++;
      if (hex_obs[h] !== 7'b1000000) begin
        errors++; $display("FAIL basic_final_hex%0d: got %b want 1000000", h, hex_obs[h]);
      end
    end
  endtask

  task automatic test_carry();
    do_reset();
    preload(1'b0);
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      for (int h = 0; h < 6; h++) begin
        checks++;
        if (hex_obs[h] !== exp_hex(m_shown, h)) begin
          errors++; $display("FAIL carry_hex%0d cyc %0d: got %b want %b", h, c, hex_obs[h], exp_hex(m_shown, h));
        end
      end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL carry_wrap cyc %0d: got %b want 0", c, wrap); end
    end
    checks++;
    if (hex2 !== 7'b1000000) begin errors++; $display("FAIL carry_hex2: got %b want 1000000", hex2); end
    checks++;
    if (hex3 !== 7'b1111001) begin errors++; $display("FAIL carry_hex3: got %b want 1111001", hex3); end
    checks++;
    if (hex1 !== 7'b1000000 || hex0 !== 7'b1000000) begin
      errors++; $display("FAIL carry_cs: got %b %b want 1000000 1000000", hex1, hex0);
    end
  endtask

  task automatic test_wrap();
    int wc;
    do_reset();
    preload(1'b1);
    run = 1'b1;
    wc = 0;
    for (int c = 1; c <= 15; c++) begin
      cycle();
      if (wrap === 1'b1) wc++;
      checks++;
      if (wrap !== m_wrap) begin errors++; $display("FAIL wrap_pulse cyc %0d: got %b want %b", c, wrap, m_wrap); end
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL wrap_running cyc %0d: got %b want 1", c, running); end
      for (int h = 0; h < 6; h++) begin
        checks++;
        if (hex_obs[h] !== exp_hex(m_shown, h)) begin
          errors++; $display("FAIL wrap_hex%0d cyc %0d: got %b want %b", h, c, hex_obs[h], exp_hex(m_shown, h));
        end
      end
    end
    checks++;
    if (wc !== 1) begin errors++; $display("FAIL wrap_count: got %0d want 1", wc); end
    for (int h = 0; h < 6; h++) begin
      checks++;
      if (hex_obs[h] !== 7'b1000000) begin
        errors++; $display("FAIL wrap_final_hex%0d: got %b want 1000000", h, hex_obs[h]);
      end
    end
  endtask

  task automatic test_pause_clear();
    int n;
    do_reset();
    run = 1'b1;
    n = 0;
    while (m_time != 3 && n < 60) begin cycle(); n++; end
    if (m_time != 3) begin errors++; $display("FAIL pause_reach: got %0d want 3", m_time); end
    run = 1'b0;
    cycle();
    for (int c = 0; c < 30; c++) begin
      cycle();
      checks++;
      if (hex0 !== 7'b0110000) begin errors++; $display("FAIL pause_hold cyc %0d: got %b want 0110000", c, hex0); end
    end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b want 0", running); end
    clear = 1'b1; cycle(); clear = 1'b0; cycle();
    for (int h = 0; h < 6; h++) begin
      checks++;
      if (hex_obs[h] !== 7'b1000000) begin
        errors++; $display("FAIL clear_hex%0d: got %b want 1000000", h, hex_obs[h]);
      end
    end
    checks++;
    if (running !== 1'b0 || m_state != S_IDLE) begin
      errors++; $display("FAIL clear_state: got running=%b want 0", running);
    end
    run = 1'b1;
    for (int c = 0; c < 30; c++) begin
      clear = (c == 14 || c == 22);
      cycle();
      checks++;
      if (running !== 1'(m_state == S_RUN)) begin
        errors++; $display("FAIL runclear_running cyc %0d: got %b want %b", c, running, m_state == S_RUN);
      end
      for (int h = 0; h < 6; h++) begin
        checks++;
        if (hex_obs[h] !== exp_hex(m_shown, h)) begin
          errors++; $display("FAIL runclear_hex%0d cyc %0d: got %b want %b", h, c, hex_obs[h], exp_hex(m_shown, h));
        end
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_blank();
    do_reset();
    run = 1'b1; cycle();
    run = 1'b0; cycle();
    force dut.digits_q = 24'h00000A;
    cycle();
    release dut.digits_q;
    checks++;
    if (hex0 !== 7'b1111111) begin errors++; $display("FAIL blank_hex0: got %b want 1111111", hex0); end
    checks++;
    if (hex1 !== 7'b1000000) begin errors++; $display("FAIL blank_hex1: got %b want 1000000", hex1); end
    do_reset();
  endtask

`ifdef STOPWATCH_LAP_HOLD_EN
  task automatic test_lap();
    int n;
    do_reset();
    run = 1'b1;
    n = 0;
    while (m_time != 4 && n < 60) begin cycle(); n++; end
    if (m_time != 4) begin errors++; $display("FAIL lap_reach: got %0d want 4", m_time); end
    lap = 1'b1; cycle(); lap = 1'b0;
    for (int c = 0; c < 50; c++) begin
      cycle();
      checks++;
      if (hex0 !== 7'b0011001) begin errors++; $display("FAIL lap_hold cyc %0d: got %b want 0011001", c, hex0); end
    end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL lap_running: got %b want 1", running); end
    lap = 1'b1; cycle(); lap = 1'b0;
    checks++;
    if (hex0 !== 7'b0010000) begin errors++; $display("FAIL lap_release: got %b want 0010000", hex0); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      clear   = ($urandom_range(0, 14) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
`ifdef STOPWATCH_LAP_HOLD_EN
      lap = ($urandom_range(0, 24) == 0);
`endif
      cycle();
      for (int h = 0; h < 6; h++) begin
        checks++;
        if (hex_obs[h] !== exp_hex(m_shown, h)) begin
          errors++; $display("FAIL rand_hex%0d cyc %0d: got %b want %b", h, c, hex_obs[h], exp_hex(m_shown, h));
        end
      end
      checks++;
      if (running !== 1'(m_state == S_RUN)) begin
        errors++; $display("FAIL rand_running cyc %0d: got %b want %b", c, running, m_state == S_RUN);
      end
      checks++;
      if (wrap !== m_wrap) begin errors++; $display("FAIL rand_wrap cyc %0d: got %b want %b", c, wrap, m_wrap); end
    end
    reset_n = 1'b1; clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_carry();
    test_wrap();
    test_pause_clear();
    test_blank();
`ifdef STOPWATCH_LAP_HOLD_EN
    test_lap();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
